alu181_regfile_datapath: RTL and testbench

//   Single-clock datapath: multi-port register file feeding a 74181-style ALU built from 4-bit slices.

---
 rtl/alu181_regfile_datapath_if.sv | 38 +++
 rtl/alu181_regfile_datapath.sv | 101 ++++++++++
 tb/tb_alu181_regfile_datapath.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu181_regfile_datapath_if.sv
// Bus bundle between the sequencer and the register-file/ALU datapath.
// master: drives register-file and ALU controls, observes read data and ALU flags.
// slave : the datapath itself.
interface alu181_regfile_datapath_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8
);
    localparam int unsigned ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  reg_write_enable;
    logic [ADDR_WIDTH-1:0] reg_read_addr1;
    logic [ADDR_WIDTH-1:0] reg_read_addr2;
    logic [ADDR_WIDTH-1:0] reg_write_addr;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic                  alu_cin;
    logic                  alu_mode;
    logic                  b_source_sel;
    logic [3:0]            alu_comm;
    logic [DATA_WIDTH-1:0] alu_b_imm;
    logic [DATA_WIDTH-1:0] reg_read_data1;
    logic [DATA_WIDTH-1:0] reg_read_data2;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_cout;
    logic                  alu_nbo;
    logic                  alu_ngo;

    modport master (
        output reg_write_enable, reg_read_addr1, reg_read_addr2, reg_write_addr,
               reg_write_data, alu_cin, alu_mode, b_source_sel, alu_comm, alu_b_imm,
        input  reg_read_data1, reg_read_data2, alu_result, alu_cout, alu_nbo, alu_ngo
    );

    modport slave (
        input  reg_write_enable, reg_read_addr1, reg_read_addr2, reg_write_addr,
               reg_write_data, alu_cin, alu_mode, b_source_sel, alu_comm, alu_b_imm,
        output reg_read_data1, reg_read_data2, alu_result, alu_cout, alu_nbo, alu_ngo
    );
endinterface

// File: rtl/alu181_regfile_datapath.sv
// Register file (2 combinational read ports, 1 write port) feeding a 74181-style
// ALU assembled from 4-bit carry-lookahead slices.
// Ports: clk, reset (async, active-high, clears the register file),
//        bus (slave modport): register-file controls/data, ALU controls,
//        read data, ALU result, carry out and active-low group P/G.
module alu181_regfile_datapath #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    alu181_regfile_datapath_if.slave    bus
);
    localparam int unsigned ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned ADDR_CMP_W = ADDR_WIDTH + 1;
    localparam int unsigned NUM_SLICES = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] read_b;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] result;

    // Addresses beyond the last register read as zero and drop writes.
    function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] addr);
        return ADDR_CMP_W'(addr) < ADDR_CMP_W'(NUM_REGS);
    endfunction

    // Register file storage; reset wins over a simultaneous write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (bus.reg_write_enable && addr_valid(bus.reg_write_addr)) begin
            regs[bus.reg_write_addr] <= bus.reg_write_data;
        end
    end

    // Combinational read ports.
    always_comb begin
        operand_a = '0;
        read_b    = '0;
        if (addr_valid(bus.reg_read_addr1)) operand_a = regs[bus.reg_read_addr1];
        if (addr_valid(bus.reg_read_addr2)) read_b    = regs[bus.reg_read_addr2];
    end

    assign operand_b = bus.b_source_sel ? bus.alu_b_imm : read_b;

    // Bit-level propagate (x) and generate (y); y implies x, so x acts as OR-propagate.
    assign x = operand_a | (operand_b & {DATA_WIDTH{bus.alu_comm[0]}})
                         | (~operand_b & {DATA_WIDTH{bus.alu_comm[1]}});
    assign y = (operand_a & ~operand_b & {DATA_WIDTH{bus.alu_comm[2]}})
             | (operand_a &  operand_b & {DATA_WIDTH{bus.alu_comm[3]}});

    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
        logic [3:0] sx;
        logic [3:0] sy;
        logic [3:0] sc;
        logic       cin_s;
        logic       sp;
        logic       sg;
        logic       cout_s;
        logic       grp_p_s;
        logic       grp_g_s;

        assign sx = x[4*gi +: 4];
        assign sy = y[4*gi +: 4];

        if (gi == 0) begin : g_lsb
            assign cin_s   = bus.alu_cin;
            assign grp_p_s = sp;
            assign grp_g_s = sg;
        end else begin : g_chain
            assign cin_s   = g_slice[gi-1].cout_s;
            assign grp_p_s = sp & g_slice[gi-1].grp_p_s;
            assign grp_g_s = sg | (sp & g_slice[gi-1].grp_g_s);
        end

        // Slice-internal lookahead carries.
        assign sc[0] = cin_s;
        assign sc[1] = sy[0] | (sx[0] & cin_s);
        assign sc[2] = sy[1] | (sx[1] & sy[0]) | (sx[1] & sx[0] & cin_s);
        assign sc[3] = sy[2] | (sx[2] & sy[1]) | (sx[2] & sx[1] & sy[0])
                     | (sx[2] & sx[1] & sx[0] & cin_s);

        assign sp = &sx;
        assign sg = sy[3] | (sx[3] & sy[2]) | (sx[3] & sx[2] & sy[1])
                  | (sx[3] & sx[2] & sx[1] & sy[0]);
        assign cout_s = sg | (sp & cin_s);

        assign result[4*gi +: 4] = bus.alu_mode ? ~(sx ^ sy) : (sx ^ sy ^ sc);
    end

    assign bus.reg_read_data1 = operand_a;
    assign bus.reg_read_data2 = read_b;
    assign bus.alu_result     = result;
    assign bus.alu_cout       = bus.alu_mode ? 1'b0 : g_slice[NUM_SLICES-1].cout_s;
    assign bus.alu_nbo        = ~g_slice[NUM_SLICES-1].grp_p_s;
    assign bus.alu_ngo        = ~g_slice[NUM_SLICES-1].grp_g_s;
endmodule

// File: tb/tb_alu181_regfile_datapath.sv
// Self-checking bench for alu181_regfile_datapath: directed cases plus random
// traffic compared against an arithmetic reference model of the register file and ALU.
module tb_alu181_regfile_datapath;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] mregs [NR];
    logic [2:0]    cur_a1;
    logic [2:0]    cur_a2;
    logic          cur_bsel;
    logic [DW-1:0] cur_imm;
    logic [3:0]    cur_s;
    logic          cur_m;
    logic          cur_cin;

    alu181_regfile_datapath_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    alu181_regfile_datapath #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU: plain integer addition of the X/Y terms.
    task automatic ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [3:0] s, input logic m, input logic cin,
                           output logic [DW-1:0] f, output logic cout,
                           output logic nbo, output logic ngo);
        logic [DW-1:0] xv;
        logic [DW-1:0] yv;
        logic [DW:0]   sum;
        logic [DW:0]   gen;
        xv  = a | (b & {DW{s[0]}}) | (~b & {DW{s[1]}});
        yv  = (a & ~b & {DW{s[2]}}) | (a & b & {DW{s[3]}});
        sum = {1'b0, xv} + {1'b0, yv} + (DW+1)'(cin);
        gen = {1'b0, xv} + {1'b0, yv};
        f    = m ? ~(xv ^ yv) : sum[DW-1:0];
        cout = m ? 1'b0 : sum[DW];
        nbo  = (xv != {DW{1'b1}});
        ngo  = ~gen[DW];
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] f;
        logic          cout;
        logic          nbo;
        logic          ngo;
        a = mregs[cur_a1];
        b = cur_bsel ? cur_imm : mregs[cur_a2];
        ref_alu(a, b, cur_s, cur_m, cur_cin, f, cout, nbo, ngo);
        check({tag, ".rd1"},  bus.reg_read_data1, a);
        check({tag, ".rd2"},  bus.reg_read_data2, mregs[cur_a2]);
        check({tag, ".f"},    bus.alu_result, f);
        check({tag, ".cout"}, DW'(bus.alu_cout), DW'(cout));
        check({tag, ".nbo"},  DW'(bus.alu_nbo), DW'(nbo));
        check({tag, ".ngo"},  DW'(bus.alu_ngo), DW'(ngo));
    endtask

    task automatic drive_ctl();
        bus.reg_read_addr1 = cur_a1;
        bus.reg_read_addr2 = cur_a2;
        bus.b_source_sel   = cur_bsel;
        bus.alu_b_imm      = cur_imm;
        bus.alu_comm       = cur_s;
        bus.alu_mode       = cur_m;
        bus.alu_cin        = cur_cin;
    endtask

    task automatic apply(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [3:0] s, input logic m, input logic cin,
                         input logic bsel, input logic [DW-1:0] imm);
        @(negedge clk);
        cur_a1 = a1; cur_a2 = a2; cur_s = s; cur_m = m;
        cur_cin = cin; cur_bsel = bsel; cur_imm = imm;
        drive_ctl();
        #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        bus.reg_write_enable = 1'b1;
        bus.reg_write_addr   = addr;
        bus.reg_write_data   = data;
        @(posedge clk);
        mregs[addr] = data;
        #1;
        bus.reg_write_enable = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        cur_a1 = 3'd1; cur_a2 = 3'd3; cur_s = 4'b0000; cur_m = 1'b0;
        cur_cin = 1'b0; cur_bsel = 1'b0; cur_imm = '0;
        drive_ctl();
        bus.reg_write_enable = 1'b0;
        bus.reg_write_addr   = '0;
        bus.reg_write_data   = '0;
        reset = 1'b1;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // AND with immediate or register operand.
        wr(3'd1, 16'h1234);
        wr(3'd3, 16'h00FF);
        apply("and_imm", 3'd1, 3'd3, 4'b1011, 1'b1, 1'b0, 1'b1, 16'h00FF);
        check("and_imm.const", bus.alu_result, 16'h0034);
        apply("and_reg", 3'd1, 3'd3, 4'b1011, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("and_reg.const", bus.alu_result, 16'h0034);
        apply("and_cin", 3'd1, 3'd3, 4'b1011, 1'b1, 1'b1, 1'b0, 16'h0000);
        check("and_cin.const", bus.alu_result, 16'h0034);
        check("and_cin.cout", DW'(bus.alu_cout), 16'h0000);

        // OR / XOR logic ops.
        apply("or_ff00", 3'd1, 3'd0, 4'b1110, 1'b1, 1'b0, 1'b1, 16'hFF00);
        check("or_ff00.const", bus.alu_result, 16'hFF34);
        apply("or_0000", 3'd1, 3'd0, 4'b1110, 1'b1, 1'b0, 1'b1, 16'h0000);
        check("or_0000.const", bus.alu_result, 16'h1234);
        wr(3'd5, 16'hAAAA);
        apply("xor_5555", 3'd5, 3'd0, 4'b0110, 1'b1, 1'b0, 1'b1, 16'h5555);
        check("xor_5555.const", bus.alu_result, 16'hFFFF);
        apply("xor_ffff", 3'd5, 3'd0, 4'b0110, 1'b1, 1'b0, 1'b1, 16'hFFFF);
        check("xor_ffff.const", bus.alu_result, 16'h5555);

        // Arithmetic.
        wr(3'd2, 16'h1234);
        wr(3'd3, 16'h5678);
        apply("add", 3'd2, 3'd3, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("add.const", bus.alu_result, 16'h68AC);
        check("add.cout", DW'(bus.alu_cout), 16'h0000);
        apply("sub", 3'd2, 3'd3, 4'b0110, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("sub.const", bus.alu_result, 16'hBBBC);
        check("sub.borrow", DW'(bus.alu_cout), 16'h0000);
        apply("add_imm", 3'd2, 3'd3, 4'b1001, 1'b0, 1'b0, 1'b1, 16'h0005);
        check("add_imm.const", bus.alu_result, 16'h1239);

        // Carry out and wrap-around, plus group P/G.
        wr(3'd4, 16'hFFFF);
        apply("dbl_wrap", 3'd4, 3'd0, 4'b1100, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("dbl_wrap.const", bus.alu_result, 16'hFFFE);
        check("dbl_wrap.cout", DW'(bus.alu_cout), 16'h0001);
        check("dbl_wrap.ngo", DW'(bus.alu_ngo), 16'h0000);
        check("dbl_wrap.nbo", DW'(bus.alu_nbo), 16'h0000);
        apply("minus1", 3'd0, 3'd0, 4'b0011, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("minus1.const", bus.alu_result, 16'hFFFF);
        check("minus1.cout", DW'(bus.alu_cout), 16'h0000);
        check("minus1.nbo", DW'(bus.alu_nbo), 16'h0000);
        check("minus1.ngo", DW'(bus.alu_ngo), 16'h0001);

        // Chained operation with write-back.
        wr(3'd6, 16'h0005);
        wr(3'd7, 16'h0003);
        apply("chain_add", 3'd6, 3'd7, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("chain_add.const", bus.alu_result, 16'h0008);
        wr(3'd6, bus.alu_result);
        apply("chain_dbl", 3'd6, 3'd7, 4'b1100, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("chain_dbl.const", bus.alu_result, 16'h0010);

        // Read-during-write returns old data until the edge.
        @(negedge clk);
        cur_a1 = 3'd2; cur_a2 = 3'd2; cur_bsel = 1'b0;
        drive_ctl();
        bus.reg_write_enable = 1'b1;
        bus.reg_write_addr   = 3'd2;
        bus.reg_write_data   = 16'hABCD;
        #1;
        check("rdw.old", bus.reg_read_data1, 16'h1234);
        @(posedge clk);
        mregs[2] = 16'hABCD;
        #1;
        bus.reg_write_enable = 1'b0;
        check("rdw.new", bus.reg_read_data1, 16'hABCD);
        check_all("rdw");

        // Asynchronous reset mid-run, overriding a pending write.
        apply("pre_rst", 3'd1, 3'd5, 4'b1001, 1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        check("rst_async.rd1", bus.reg_read_data1, 16'h0000);
        check("rst_async.rd2", bus.reg_read_data2, 16'h0000);
        check_all("rst_async");
        bus.reg_write_enable = 1'b1;
        bus.reg_write_addr   = 3'd1;
        bus.reg_write_data   = 16'hFFFF;
        @(posedge clk);
        #1;
        check("rst_override", bus.reg_read_data1, 16'h0000);
        @(negedge clk);
        bus.reg_write_enable = 1'b0;
        reset = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(0, NR - 1)), 16'($urandom()));
            apply("rand", 3'($urandom_range(0, NR - 1)), 3'($urandom_range(0, NR - 1)),
                  4'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                  16'($urandom()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
